// File: rtl/patterns_pkg.sv
// Shared constants for the pattern-index generator and its Gray-code consumer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package patterns_pkg;

  localparam int WIDTH  = 12;
  localparam int STEP_W = 4;

  localparam logic [1:0] MODE_ONCE   = 2'b00;
  localparam logic [1:0] MODE_LOOP   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // The reserved encoding 2'b11 behaves like ONCE.
  function automatic logic is_once(input logic [1:0] mode);
    return (mode != MODE_LOOP) && (mode != MODE_BOUNCE);
  endfunction

endpackage

// File: rtl/pattern_step_calc.sv
// Combinational next-index, next-direction and end-of-run computation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller applies the result only on a handshake.
module pattern_step_calc
  import patterns_pkg::*;
#(
  parameter int WIDTH  = patterns_pkg::WIDTH,
  parameter int STEP_W = patterns_pkg::STEP_W
) (
  input  logic [WIDTH-1:0]  index,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  input  logic              dir_dn,
  output logic [WIDTH-1:0]  nxt_index,
  output logic              nxt_dir_dn,
  output logic              end_once
);

  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_diff;
  logic [WIDTH:0]   lo_up;
  logic [WIDTH:0]   hi_dn;
  logic [WIDTH-1:0] up_clamp;
  logic [WIDTH-1:0] dn_clamp;
  logic [WIDTH-1:0] from_lo;
  logic [WIDTH-1:0] from_hi;

  // Candidate indices, all one bit wider so carry/borrow cannot fake a wrap.
  always_comb begin
    step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    up_sum   = {1'b0, index} + step_ext;
    dn_diff  = {1'b0, index} - step_ext;
    lo_up    = {1'b0, lo} + step_ext;
    hi_dn    = {1'b0, hi} - step_ext;
    up_clamp = (up_sum > {1'b0, hi}) ? hi : up_sum[WIDTH-1:0];
    from_lo  = (lo_up > {1'b0, hi}) ? hi : lo_up[WIDTH-1:0];
    dn_clamp = (dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < lo)) ? lo : dn_diff[WIDTH-1:0];
    from_hi  = (hi_dn[WIDTH] || (hi_dn[WIDTH-1:0] < lo)) ? lo : hi_dn[WIDTH-1:0];
  end

  // Select the move: walk inside the range, or apply the end-of-range action.
  always_comb begin
    nxt_index  = index;
    nxt_dir_dn = dir_dn;
    end_once   = 1'b0;
    if ((mode == MODE_BOUNCE) && dir_dn) begin
      if (index == lo) begin
        // Turn around at the bottom and take the first upward step at once.
        nxt_dir_dn = 1'b0;
        nxt_index  = from_lo;
      end else begin
        nxt_index = dn_clamp;
      end
    end else if (index == hi) begin
      if (mode == MODE_LOOP) begin
        nxt_index = lo;
      end else if (mode == MODE_BOUNCE) begin
        nxt_dir_dn = 1'b1;
        nxt_index  = from_hi;
      end else begin
        end_once = 1'b1;
      end
    end else begin
      nxt_index = up_clamp;
    end
  end

endmodule

// File: rtl/pattern_index_gen.sv
// Walks [lo, hi] by a programmable step in ONCE/LOOP/BOUNCE mode, feeding Binary2Gray.
// Latency: first index valid one cycle after start; one index per handshake after that.
// Backpressure: index and out_valid hold while out_ready is low; only stop/reset drop valid.
module pattern_index_gen
  import patterns_pkg::*;
#(
  parameter int WIDTH  = patterns_pkg::WIDTH,
  parameter int STEP_W = patterns_pkg::STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  cfg_lo,
  input  logic [WIDTH-1:0]  cfg_hi,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [1:0]        cfg_mode,
  input  logic              start,
  input  logic              stop,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  index,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  logic [1:0]        state_q,  state_d;
  logic [WIDTH-1:0]  index_q,  index_d;
  logic              vld_q,    vld_d;
  logic              dir_q,    dir_d;
  logic              done_q,   done_d;
  logic              err_q,    err_d;
  logic [WIDTH-1:0]  lo_q,     lo_d;
  logic [WIDTH-1:0]  hi_q,     hi_d;
  logic [STEP_W-1:0] step_q,   step_d;
  logic [1:0]        mode_q,   mode_d;

  logic [WIDTH-1:0]  calc_index;
  logic              calc_dir;
  logic              calc_end;
  logic              hs;

  pattern_step_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step_calc (
    .index      (index_q),
    .lo         (lo_q),
    .hi         (hi_q),
    .step       (step_q),
    .mode       (mode_q),
    .dir_dn     (dir_q),
    .nxt_index  (calc_index),
    .nxt_dir_dn (calc_dir),
    .end_once   (calc_end)
  );

  assign hs = vld_q && out_ready;

  // FSM, config latch and handshake; stop outranks start, start outranks a handshake.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    vld_d   = vld_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = err_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    step_d  = step_q;
    mode_d  = mode_q;
    if (stop) begin
      vld_d   = 1'b0;
      state_d = ST_IDLE;
    end else if (start && (cfg_lo > cfg_hi)) begin
      // A bad start is flagged and otherwise ignored, so a running walk carries on.
      err_d = 1'b1;
      if ((state_q == ST_RUN) && hs && !calc_end) begin
        index_d = calc_index;
        dir_d   = calc_dir;
      end else if ((state_q == ST_RUN) && hs) begin
        vld_d   = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end else if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end else if (start) begin
      err_d   = 1'b0;
      lo_d    = cfg_lo;
      hi_d    = cfg_hi;
      step_d  = (cfg_step == '0) ? {{(STEP_W - 1){1'b0}}, 1'b1} : cfg_step;
      mode_d  = cfg_mode;
      index_d = cfg_lo;
      dir_d   = 1'b0;
      vld_d   = 1'b1;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hs) begin
            if (calc_end) begin
              vld_d   = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              index_d = calc_index;
              dir_d   = calc_dir;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      vld_q   <= 1'b0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      step_q  <= {{(STEP_W - 1){1'b0}}, 1'b1};
      mode_q  <= MODE_ONCE;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      vld_q   <= vld_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
    end
  end

  assign out_valid = vld_q;
  assign index     = index_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule

// File: doc/pattern_index_gen.md
Name: pattern_index_gen

Overview:
- Sequential 12-bit binary pattern-index generator. Sits directly upstream of the Binary2Gray stage; its `index` output drives the converter input.
- Walks a programmable range [lo, hi] with a programmable step in one of three modes.
- Presents each index with a valid/ready handshake so the downstream Gray path can stall it.
- One clock. Reset is asynchronous and active-low.

Parameters:
- WIDTH, 12, index width; must match the Gray converter width.
- STEP_W, 4, width of the step input; legal step values are 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_lo  in  WIDTH  first index of range; sampled on start.
- cfg_hi  in  WIDTH  last index of range; sampled on start.
- cfg_step  in  STEP_W  increment magnitude; sampled on start; 0 treated as 1.
- cfg_mode  in  2  00 ONCE, 01 LOOP, 10 BOUNCE, 11 reserved (treated as ONCE).
- start  in  1  one-cycle pulse: latch config and begin.
- stop  in  1  one-cycle pulse: abort to IDLE.
- out_ready  in  1  downstream accepts index this cycle.
- out_valid  out  1  index is valid.
- index  out  WIDTH  current binary index (registered).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when ONCE mode finishes.
- cfg_err  out  1  sticky; set when start is seen with cfg_lo > cfg_hi; cleared by next good start.

Behaviour:
- Reset values: out_valid=0, index=0, busy=0, done=0, cfg_err=0, direction=up, state=IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start with lo<=hi: latch lo/hi/step/mode, index<=lo, out_valid<=1, go RUN. First index appears the cycle after start (latency 1).
  - start with lo>hi: cfg_err<=1, remain IDLE.
- RUN:
  - index advances only on handshake (out_valid & out_ready).
  - Without handshake, index and out_valid hold exactly.
- Advance, up direction:
  - next = index + step, computed WIDTH+1 bits wide.
  - If next > hi (including carry-out), the index clamps to hi, unless index already equals hi; then the end-of-range action applies.
- Advance, down direction (BOUNCE only):
  - prev = index - step, computed with borrow.
  - If the result is below lo or borrows, the index clamps to lo, unless index already equals lo; then the direction flips to up.
- End-of-range action:
  - ONCE: the last handshake at hi gives out_valid<=0, done pulse 1 cycle, state DONE.
  - LOOP: index<=lo.
  - BOUNCE: direction flips to down and index<=hi-step, clamped to lo. If lo==hi, index stays lo.
- lo==hi: a single index is emitted; ONCE finishes after one handshake, LOOP/BOUNCE repeat it.
- Full range lo=0, hi=4095: no wrap through 0 except by the LOOP rule; the carry bit prevents false wrap.
- DONE: go to IDLE next cycle. Outputs idle values; index holds its last value.
- stop has priority over start and over any handshake in the same cycle: out_valid<=0, busy<=0, no done pulse, go IDLE, index holds.
- start while in RUN (no stop): restart with new config, same as from IDLE. A handshake in the same cycle is consumed but ignored.
- Asynchronous reset mid-operation: all outputs return to reset values immediately, independent of clk.
- The handshake must be stall-safe: out_valid never drops without a handshake, except on stop or reset.

Decomposition:
- Shared package `patterns_pkg`:
  - WIDTH constant (12), shared with Binary2Gray.
  - Mode encodings MODE_ONCE/LOOP/BOUNCE.
  - FSM state encodings.
- Natural sub-module `pattern_step_calc`: combinational next-index/direction/end-flag computation from index, lo, hi, step, mode, dir.
- Top module holds the FSM, config registers and handshake.

Test Plan:
- ONCE lo=10 hi=20 step=4, out_ready=1: indices 10,14,18,20, then done pulse; out_valid=0 after 20.
- LOOP lo=4093 hi=4095 step=1: 4093,4094,4095,4093,… with no carry-induced wrap to 0.
- BOUNCE lo=0 hi=6 step=3: 0,3,6,3,0,3,6…; step=0 behaves as step=1.
- Backpressure: out_ready toggled 1,0,0,1 in LOOP: index holds through stalls, no index skipped or duplicated.
- Boundary and error starts:
  - start with lo=50 hi=40: cfg_err=1, state stays IDLE, out_valid=0.
  - A subsequent valid start clears cfg_err.
  - lo=hi=7 in ONCE: single 7, then done.
- Abort and reset:
  - stop and start asserted in the same cycle mid-RUN: IDLE, out_valid=0, no done.
  - rst_n pulsed low mid-RUN between clock edges: outputs go to reset values immediately.
